// File: rtl/ifetch_line_controller.sv
// Single-line instruction fetch buffer between the core's fetch stage and InstructionMemory.
// Fills one 128-bit line at a time and returns the addressed 32-bit word with hit/miss counters.
module ifetch_line_controller #(
    parameter int FILL_CYCLES = 6,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_address,
    input  logic              flush,
    output logic              cpu_ready,
    output logic [31:0]       cpu_instr,
    output logic              busy,
    output logic [31:0]       mem_address,
    input  logic [127:0]      mem_dataline,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    // Handshake: cpu_req is sampled only in IDLE; the core holds it until the single-cycle
    // cpu_ready pulse, and a request seen during FILL or RESPOND is never accepted.
    typedef enum logic [1:0] {IDLE, FILL, RESPOND} state_t;

    localparam logic [7:0] FILL_LAST = 8'(FILL_CYCLES - 1);

    state_t       state, state_next;
    logic         valid;
    logic [27:0]  tag;
    logic [127:0] line;
    logic [31:0]  req_addr;
    logic [7:0]   fill_cnt;
    logic         flush_seen;
    logic         is_hit;
    logic         fill_done;

    // Word 0 sits in the most significant slot of the line.
    function automatic logic [31:0] select_word(input logic [127:0] l, input logic [1:0] k);
        case (k)
            2'd0:    return l[127:96];
            2'd1:    return l[95:64];
            2'd2:    return l[63:32];
            default: return l[31:0];
        endcase
    endfunction

    assign is_hit    = valid && (tag == cpu_address[31:4]) && !flush;
    assign fill_done = (state == FILL) && (fill_cnt == FILL_LAST);
    assign cpu_ready = (state == RESPOND);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) state_next = is_hit ? RESPOND : FILL;
            end
            FILL: begin
                if (fill_done) state_next = RESPOND;
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid       <= 1'b0;
            tag         <= '0;
            line        <= '0;
            req_addr    <= '0;
            fill_cnt    <= '0;
            flush_seen  <= 1'b0;
            cpu_instr   <= '0;
            mem_address <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr <= cpu_address;
                        if (is_hit) begin
                            cpu_instr <= select_word(line, cpu_address[3:2]);
                            if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        end else begin
                            mem_address <= {cpu_address[31:4], 4'b0000};
                            fill_cnt    <= '0;
                            flush_seen  <= 1'b0;
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        end
                    end
                    if (flush) valid <= 1'b0;
                end
                FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (flush) flush_seen <= 1'b0 | 1'b1;
                    if (fill_done) begin
                        line      <= mem_dataline;
                        tag       <= req_addr[31:4];
                        // A flush anywhere in the fill window leaves the new line unusable.
                        valid     <= !(flush_seen || flush);
                        cpu_instr <= select_word(mem_dataline, req_addr[3:2]);
                    end
                end
                RESPOND: begin
                    if (flush) valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_line_controller.sv
// Directed bench for ifetch_line_controller with a latency-modelled instruction memory
// and a scoreboard queue of expected instructions checked on every cpu_ready.
module tb_ifetch_line_controller;

    localparam int FILL_CYCLES = 6;
    localparam int CNT_W       = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic [31:0]       cpu_address;
    logic              flush;
    logic              cpu_ready;
    logic [31:0]       cpu_instr;
    logic              busy;
    logic [31:0]       mem_address;
    logic [127:0]      mem_dataline;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    int tests = 0;
    int fails = 0;

    logic [31:0]      exp_q[$];
    logic [CNT_W-1:0] exp_hits;
    logic [CNT_W-1:0] exp_misses;
    logic [31:0]      last_line;

    ifetch_line_controller #(.FILL_CYCLES(FILL_CYCLES), .CNT_W(CNT_W)) dut (
        .clock(clk), .reset(rst), .cpu_req(cpu_req), .cpu_address(cpu_address),
        .flush(flush), .cpu_ready(cpu_ready), .cpu_instr(cpu_instr), .busy(busy),
        .mem_address(mem_address), .mem_dataline(mem_dataline),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: byte array, data valid only after the address is stable for 5 negedges.
    logic [7:0]  mem_bytes [0:255];
    logic [31:0] seen_addr = 32'hFFFF_FFFF;
    int          stable = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {mem_bytes[b + 8'd3], mem_bytes[b + 8'd2], mem_bytes[b + 8'd1], mem_bytes[b]};
    endfunction

    function automatic logic [127:0] line_at(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:4], 4'b0000};
        return {word_at(base), word_at(base + 32'd4), word_at(base + 32'd8), word_at(base + 32'd12)};
    endfunction

    always @(negedge clk) begin
        if (mem_address !== seen_addr) begin
            seen_addr = mem_address;
            stable = 1;
        end else if (stable < 8) begin
            stable = stable + 1;
        end
    end

    assign mem_dataline = (stable >= 5) ? line_at(seen_addr) : {4{32'hDEAD_BEEF}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every cpu_ready pops one expected instruction.
    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                check("cpu_instr", cpu_instr, exp_q.pop_front());
            end
        end
    end

    // Driver: one request; flush_at = 0 flushes with the request, k>0 flushes in FILL cycle k.
    task automatic do_req(input logic [31:0] addr, input bit exp_hit, input int flush_at);
        int lat;
        exp_q.push_back(word_at(addr));
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_address = addr;
        flush       = (flush_at == 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (exp_hit) begin
            exp_hits = sat_inc(exp_hits);
        end else begin
            exp_misses = sat_inc(exp_misses);
            last_line  = {addr[31:4], 4'b0000};
        end
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        check("miss_count", 32'(miss_count), 32'(exp_misses));
        lat = 1;
        while (!cpu_ready && lat < 40) begin
            check("mem_address_fill", mem_address, last_line);
            check("busy_fill", 32'(busy), 32'd1);
            flush = (lat == flush_at);
            @(posedge clk);
            #1;
            flush = 1'b0;
            lat++;
        end
        check("ready", 32'(cpu_ready), 32'd1);
        check("latency", 32'(lat), exp_hit ? 32'd1 : 32'(FILL_CYCLES + 1));
        check("mem_address", mem_address, last_line);
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'(i * 37 + 11);
        mem_bytes[0] = 8'h20; mem_bytes[1] = 8'h30; mem_bytes[2] = 8'h80; mem_bytes[3] = 8'h04;
        mem_bytes[4] = 8'h24; mem_bytes[5] = 8'h22; mem_bytes[6] = 8'h00; mem_bytes[7] = 8'h08;

        rst = 1'b1; cpu_req = 1'b0; cpu_address = '0; flush = 1'b0;
        exp_hits = '0; exp_misses = '0; last_line = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(cpu_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_instr", cpu_instr, 32'd0);
        check("reset_mem_address", mem_address, 32'd0);
        check("reset_hits", 32'(hit_count), 32'd0);
        check("reset_misses", 32'(miss_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, then hits on the same line (bits [1:0] ignored).
        check("word0_model", word_at(32'h0), 32'h0480_3020);
        do_req(32'h0000_0000, 1'b0, -1);
        do_req(32'h0000_0004, 1'b1, -1);
        do_req(32'h0000_0006, 1'b1, -1);

        // Line change: one-line buffer means returning to line 0 misses again.
        do_req(32'h0000_0010, 1'b0, -1);
        do_req(32'h0000_0000, 1'b0, -1);

        // Flush in IDLE.
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("busy_after_flush", 32'(busy), 32'd0);
        do_req(32'h0000_0000, 1'b0, -1);
        do_req(32'h0000_0008, 1'b1, -1);

        // Flush in FILL cycle 3: response delivered, line left invalid.
        do_req(32'h0000_0010, 1'b0, 3);
        do_req(32'h0000_0014, 1'b0, -1);
        do_req(32'h0000_0018, 1'b1, -1);

        // Flush together with a would-be hit forces a miss.
        do_req(32'h0000_001C, 1'b0, 0);

        // Hit counter saturation.
        do_req(32'h0000_0030, 1'b0, -1);
        for (int i = 0; i < 17; i++) do_req(32'h0000_0030 + 32'(4 * (i % 4)), 1'b1, -1);
        check("hit_saturated", 32'(hit_count), 32'(CNT_MAX));

        // Reset in FILL cycle 2: everything clears at once, no response follows.
        @(negedge clk);
        cpu_req = 1'b1; cpu_address = 32'h0000_0020;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        cpu_req = 1'b0;
        exp_hits = '0; exp_misses = '0; last_line = '0;
        check("abort_ready", 32'(cpu_ready), 32'd0);
        check("abort_busy_cleared", 32'(busy), 32'd0);
        check("abort_hits", 32'(hit_count), 32'd0);
        check("abort_misses", 32'(miss_count), 32'd0);
        check("abort_mem_address", mem_address, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_idle", 32'(busy), 32'd0);
        do_req(32'h0000_0020, 1'b0, -1);
        do_req(32'h0000_0024, 1'b1, -1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
